// File: rtl/seven_seg_capture_if.sv
// Display-line bundle between a 7-segment scan driver and its capture monitor.
// Carries the sampled pins plus the reassembled frame results.
interface seven_seg_capture_if;
  logic [3:0]  Anode_Activate_in;
  logic [6:0]  LED_out_in;
  logic [15:0] captured_bcd;
  logic [13:0] captured_value;
  logic        frame_valid;
  logic        frame_error;

  modport master (
    output Anode_Activate_in,
    output LED_out_in,
    input  captured_bcd,
    input  captured_value,
    input  frame_valid,
    input  frame_error
  );

  modport slave (
    input  Anode_Activate_in,
    input  LED_out_in,
    output captured_bcd,
    output captured_value,
    output frame_valid,
    output frame_error
  );
endinterface

// File: rtl/seven_seg_capture.sv
// Captures a multiplexed 4-digit 7-segment scan back into BCD and binary.
// Each slot is accepted once after its pins stay stable for STABLE_CYCLES.
module seven_seg_capture #(
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 11
) (
  input  logic               clock_100Mhz,
  input  logic               reset,
  seven_seg_capture_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    CONVERT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(STABLE_CYCLES - 1);

  logic [10:0]      sync_q, sync_d;
  logic [10:0]      pair_q, pair_d;
  logic [10:0]      prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seen_q, seen_d;
  state_t           state_q, state_d;
  logic [1:0]       exp_q, exp_d;
  logic [1:0]       k_q, k_d;
  logic [3:0][3:0]  dig_q, dig_d;
  logic             err_q, err_d;
  logic [13:0]      acc_q, acc_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [13:0]      val_q, val_d;
  logic             fv_q, fv_d;
  logic             fe_q, fe_d;

  logic [3:0]  anode;
  logic [6:0]  cath;
  logic [1:0]  slot;
  logic        slot_ok;
  logic        anode_bad;
  logic [3:0]  digit;
  logic        cath_bad;
  logic        stable;
  logic        accept;
  logic [13:0] acc_next;

  assign anode = pair_q[10:7];
  assign cath  = pair_q[6:0];

  always_comb begin
    slot      = 2'd0;
    slot_ok   = 1'b0;
    anode_bad = 1'b0;
    unique case (anode)
      4'b0111: begin slot = 2'd0; slot_ok = 1'b1; end
      4'b1011: begin slot = 2'd1; slot_ok = 1'b1; end
      4'b1101: begin slot = 2'd2; slot_ok = 1'b1; end
      4'b1110: begin slot = 2'd3; slot_ok = 1'b1; end
      4'b1111: anode_bad = 1'b0;
      default: anode_bad = 1'b1;
    endcase
  end

  always_comb begin
    digit    = 4'hF;
    cath_bad = 1'b0;
    unique case (cath)
      7'b0000001: digit = 4'd0;
      7'b1001111: digit = 4'd1;
      7'b0010010: digit = 4'd2;
      7'b0000110: digit = 4'd3;
      7'b1001100: digit = 4'd4;
      7'b0100100: digit = 4'd5;
      7'b0100000: digit = 4'd6;
      7'b0001111: digit = 4'd7;
      7'b0000000: digit = 4'd8;
      7'b0000100: digit = 4'd9;
      default:    cath_bad = 1'b1;
    endcase
  end

  assign stable   = (pair_q == prev_q);
  assign accept   = stable && (cnt_q == CNT_MAX)
                    && !seen_q && slot_ok;
  assign acc_next = (acc_q << 3) + (acc_q << 1)
                    + {10'd0, dig_q[k_q]};

  always_comb begin
    sync_d  = {bus.Anode_Activate_in, bus.LED_out_in};
    pair_d  = sync_q;
    prev_d  = pair_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    state_d = state_q;
    exp_d   = exp_q;
    k_d     = k_q;
    dig_d   = dig_q;
    err_d   = err_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    val_d   = val_q;
    fv_d    = 1'b0;
    fe_d    = 1'b0;

    if (stable) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d  = '0;
      seen_d = 1'b0;
    end
    if (accept) seen_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (accept && slot == 2'd0) begin
          dig_d[0] = digit;
          err_d    = cath_bad;
          exp_d    = 2'd1;
          state_d  = COLLECT;
        end
      end
      COLLECT: begin
        if (anode_bad) err_d = 1'b1;
        if (accept) begin
          if (slot == exp_q) begin
            dig_d[slot] = digit;
            err_d       = err_q | anode_bad | cath_bad;
            exp_d       = exp_q + 2'd1;
            if (slot == 2'd3) begin
              state_d = CONVERT;
              k_d     = 2'd0;
              acc_d   = '0;
            end
          end else if (slot == 2'd0) begin
            dig_d[0] = digit;
            err_d    = cath_bad;
            exp_d    = 2'd1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      CONVERT: begin
        acc_d = acc_next;
        k_d   = k_q + 2'd1;
        // last step also loads the outputs so they show during DONE
        if (k_q == 2'd3) begin
          state_d = DONE;
          fv_d    = 1'b1;
          fe_d    = err_q;
          bcd_d   = {dig_q[0], dig_q[1], dig_q[2], dig_q[3]};
          val_d   = err_q ? 14'd0 : acc_next;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      sync_q  <= '1;
      pair_q  <= '1;
      prev_q  <= '1;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      state_q <= IDLE;
      exp_q   <= 2'd0;
      k_q     <= 2'd0;
      dig_q   <= '0;
      err_q   <= 1'b0;
      acc_q   <= '0;
      bcd_q   <= '0;
      val_q   <= '0;
      fv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      pair_q  <= pair_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      state_q <= state_d;
      exp_q   <= exp_d;
      k_q     <= k_d;
      dig_q   <= dig_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      val_q   <= val_d;
      fv_q    <= fv_d;
      fe_q    <= fe_d;
    end
  end

  assign bus.captured_bcd   = bcd_q;
  assign bus.captured_value = val_q;
  assign bus.frame_valid    = fv_q;
  assign bus.frame_error    = fe_q;

endmodule
